// File: rtl/cpu_core.sv
// rtl/cpu_core.sv - multi-cycle accumulator CPU with req/ready instruction and data memory ports
// Defining CPU_RETIRE_CNT_EN adds the retired_cnt port and its instruction counter.
module cpu_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [ADDR_W+3:0] imem_rdata,
  input  logic              imem_ready,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
`ifdef CPU_RETIRE_CNT_EN
  output logic [31:0]       retired_cnt,
`endif
  output logic              halted
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_MEM, S_EXEC, S_HALT} state_t;

  localparam logic [3:0] OP_LDI = 4'h1, OP_LD  = 4'h2, OP_ST  = 4'h3, OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7, OP_XOR = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9, OP_JZ  = 4'hA, OP_JC  = 4'hB, OP_OUT = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mdata;
  logic              z_flag;
  logic              c_flag;
  logic [DATA_W-1:0] op_data;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              writes_acc;
  logic              branch_taken;

  assign imem_addr = pc;
  assign op_data   = DATA_W'(operand);

  // Result of the instruction in EXEC; carry defaults to the held flag so logic ops leave it alone
  always_comb begin
    alu_res      = acc;
    alu_c        = c_flag;
    writes_acc   = 1'b1;
    branch_taken = 1'b0;
    case (opcode)
      OP_LDI: alu_res = op_data;
      OP_LD:  alu_res = mdata;
      OP_ADD: {alu_c, alu_res} = {1'b0, acc} + {1'b0, mdata};
      OP_SUB: begin
        alu_res = acc - mdata;
        alu_c   = (acc < mdata);
      end
      OP_AND: alu_res = acc & mdata;
      OP_OR:  alu_res = acc | mdata;
      OP_XOR: alu_res = acc ^ mdata;
      OP_JMP: begin writes_acc = 1'b0; branch_taken = 1'b1;   end
      OP_JZ:  begin writes_acc = 1'b0; branch_taken = z_flag; end
      OP_JC:  begin writes_acc = 1'b0; branch_taken = c_flag; end
      default: writes_acc = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_FETCH;
      pc         <= '0;
      opcode     <= '0;
      operand    <= '0;
      acc        <= '0;
      mdata      <= '0;
      z_flag     <= 1'b0;
      c_flag     <= 1'b0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      out        <= '0;
      out_valid  <= 1'b0;
      halted     <= 1'b0;
`ifdef CPU_RETIRE_CNT_EN
      retired_cnt <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_FETCH: begin
          // Only the first fetch after reset arrives here with req low
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ready) begin
            opcode   <= imem_rdata[ADDR_W+3:ADDR_W];
            operand  <= imem_rdata[ADDR_W-1:0];
            pc       <= pc + ADDR_W'(1);
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              dmem_req   <= 1'b1;
              dmem_we    <= (opcode == OP_ST);
              dmem_addr  <= operand;
              dmem_wdata <= acc;
              state      <= S_MEM;
            end
            OP_HLT: begin
              halted <= 1'b1;
              state  <= S_HALT;
`ifdef CPU_RETIRE_CNT_EN
              retired_cnt <= retired_cnt + 32'd1;
`endif
            end
            default: state <= S_EXEC;
          endcase
        end
        S_MEM: begin
          if (dmem_ready) begin
            if (!dmem_we) mdata <= dmem_rdata;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (writes_acc) begin
            acc    <= alu_res;
            z_flag <= (alu_res == '0);
            c_flag <= alu_c;
          end
          if (opcode == OP_OUT) begin
            out       <= acc;
            out_valid <= 1'b1;
          end
          // pc already points past this instruction; a taken branch replaces it
          if (branch_taken) pc <= operand;
          imem_req <= 1'b1;
          state    <= S_FETCH;
`ifdef CPU_RETIRE_CNT_EN
          retired_cnt <= retired_cnt + 32'd1;
`endif
        end
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
